pixel_read_arbiter: RTL

Shares the single read port of the star-image pixel memory (160x120, 3-bit colour) among several star-mapping requesters. Examples are the top/bottom mapper, the left and right column mappers, and the raster scanner. Each cycle, the block grants one requester in round-robin order and converts its (x, y) coordinate to a linear address. It then routes the returned colour back to the owning requester after a fixed latency. It sits between the mapping datapath and the on-chip image ROM/RAM; the master FSM can freeze it with `pause`.

---
 rtl/pixel_read_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pixel_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pixel memory read port among NREQ requesters.
// Converts the winner's (x, y) into a linear address and routes the returned colour to its owner.
module pixel_read_arbiter #(
  parameter int NREQ   = 4,
  parameter int xSz    = 8,
  parameter int ySz    = 7,
  parameter int colSz  = 3,
  parameter int XMAX   = 160,
  parameter int YMAX   = 120,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pause,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*xSz-1:0]   x_in,
  input  logic [NREQ*ySz-1:0]   y_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [colSz-1:0]      rdata,
  output logic                  roob,
  output logic [14:0]           mem_addr,
  output logic                  mem_rden,
  input  logic [colSz-1:0]      mem_q
);

  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = RD_LAT + 1;
  localparam logic [xSz:0]     XLIM = XMAX[xSz:0];
  localparam logic [ySz:0]     YLIM = YMAX[ySz:0];
  localparam logic [NREQ-1:0]  ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  // Row stride of 160 expressed as 128 + 32
  function automatic logic [14:0] lin_addr(input logic [ySz-1:0] y, input logic [xSz-1:0] x);
    logic [14:0] yw;
    logic [14:0] xw;
    yw = 15'(y);
    xw = 15'(x);
    return (yw << 3'd7) + (yw << 3'd5) + xw;
  endfunction

  logic [PW-1:0]    ptr_r;
  logic [NREQ-1:0]  gnt_s;
  logic [PW-1:0]    gidx_s;
  logic             hit_s;
  logic             accept_s;
  logic [xSz-1:0]   sel_x_s;
  logic [ySz-1:0]   sel_y_s;
  logic             oob_s;
  logic             tag_vld_r [DEPTH];
  logic [PW-1:0]    tag_own_r [DEPTH];
  logic             tag_oob_r [DEPTH];
  logic [NREQ-1:0]  rvalid_r;
  logic [colSz-1:0] rdata_r;
  logic             roob_r;
  logic [14:0]      mem_addr_r;
  logic             mem_rden_r;

  // Round-robin search from ptr; descending offsets so the nearest request wins
  always_comb begin
    gnt_s  = '0;
    gidx_s = '0;
    hit_s  = 1'b0;
    if (!pause && !reset) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        gidx_s = req[(int'(ptr_r) + k) % NREQ] ? PW'((int'(ptr_r) + k) % NREQ) : gidx_s;
        hit_s  = hit_s | req[(int'(ptr_r) + k) % NREQ];
      end
      gnt_s = hit_s ? (ONE << gidx_s) : '0;
    end else begin
      gnt_s = '0;
    end
  end

  assign gnt      = gnt_s;
  assign accept_s = |(req & gnt_s);
  assign sel_x_s  = x_in[gidx_s*xSz +: xSz];
  assign sel_y_s  = y_in[gidx_s*ySz +: ySz];
  assign oob_s    = ({1'b0, sel_x_s} >= XLIM) || ({1'b0, sel_y_s} >= YLIM);

  // Pointer moves just past the accepted requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (accept_s) begin
      ptr_r <= (gidx_s == PW'(NREQ - 1)) ? '0 : gidx_s + 1'b1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Memory request; out-of-range reads keep the old address and skip the read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_r <= 15'd0;
      mem_rden_r <= 1'b0;
    end else if (accept_s && !oob_s) begin
      mem_addr_r <= lin_addr(sel_y_s, sel_x_s);
      mem_rden_r <= 1'b1;
    end else begin
      mem_addr_r <= mem_addr_r;
      mem_rden_r <= 1'b0;
    end
  end

  // Tag pipeline tracks owner and range flag of every in-flight read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_vld_r[i] <= 1'b0;
        tag_own_r[i] <= '0;
        tag_oob_r[i] <= 1'b0;
      end
    end else begin
      tag_vld_r[0] <= accept_s;
      tag_own_r[0] <= gidx_s;
      tag_oob_r[0] <= oob_s;
      for (int i = 1; i < DEPTH; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_own_r[i] <= tag_own_r[i-1];
        tag_oob_r[i] <= tag_oob_r[i-1];
      end
    end
  end

  // Return stage: the last tag lines up with mem_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_r <= '0;
      rdata_r  <= '0;
      roob_r   <= 1'b0;
    end else if (tag_vld_r[DEPTH-1]) begin
      rvalid_r <= ONE << tag_own_r[DEPTH-1];
      rdata_r  <= tag_oob_r[DEPTH-1] ? '0 : mem_q;
      roob_r   <= tag_oob_r[DEPTH-1];
    end else begin
      rvalid_r <= '0;
      rdata_r  <= rdata_r;
      roob_r   <= 1'b0;
    end
  end

  assign rvalid   = rvalid_r;
  assign rdata    = rdata_r;
  assign roob     = roob_r;
  assign mem_addr = mem_addr_r;
  assign mem_rden = mem_rden_r;

endmodule
